run_det_ctrl: RTL and testbench

Programmable controller for a consecutive-ones run detector on a serial input `ina`. Software or an upstream FSM arms it with a run-length threshold and a timeout window. The block sequences detection and holds the `hit` level for as long as the run continues. It reports each detection through a req/ack event handshake, keeps a saturating event count, and flags a timeout if no run qualifies within the window. It sits between the control path and the serial input: with threshold 3 it reproduces three-ones detection, and it adds arming, reporting and abort.

---
 rtl/run_det_ctrl_if.sv | 29 ++
 rtl/run_det_ctrl.sv | 132 +++++++++++++
 tb/tb_run_det_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_det_ctrl_if.sv
// Control, serial-data and event-report signals of the run detector controller.
// The master side arms, aborts and acknowledges; the slave side is the controller.
interface run_det_ctrl_if #(
    parameter int CNT_W = 4,
    parameter int TO_W  = 8,
    parameter int EVT_W = 8
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] thresh;
    logic [TO_W-1:0]  timeout;
    logic             ina;
    logic             busy;
    logic             hit;
    logic             evt_req;
    logic             evt_ack;
    logic [EVT_W-1:0] evt_cnt;
    logic             timeout_flag;

    modport master (
        output start, stop, thresh, timeout, ina, evt_ack,
        input  busy, hit, evt_req, evt_cnt, timeout_flag
    );

    modport slave (
        input  start, stop, thresh, timeout, ina, evt_ack,
        output busy, hit, evt_req, evt_cnt, timeout_flag
    );
endinterface

// File: rtl/run_det_ctrl.sv
// Armable consecutive-ones run detector with timeout window, req/ack event
// reporting and a saturating detection count. All outputs come from flops.
module run_det_ctrl #(
    parameter int CNT_W = 4,
    parameter int TO_W  = 8,
    parameter int EVT_W = 8
) (
    input logic          clk,
    input logic          rst,
    run_det_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, HIT, REPORT, TMO} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [TO_W-1:0]  win_cnt_q, win_cnt_d;
    logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic             evt_req_q, evt_req_d;
    logic             busy_q, hit_q, tmo_q;

    logic [CNT_W:0]   run_inc;
    logic [TO_W:0]    win_inc;
    logic             run_done, win_done, ack_now;

    // Widened increments so a threshold of all-ones can still be matched.
    assign run_inc  = (CNT_W+1)'(run_cnt_q) + (CNT_W+1)'(1);
    assign win_inc  = (TO_W+1)'(win_cnt_q) + (TO_W+1)'(1);
    assign run_done = bus.ina && (run_inc == (CNT_W+1)'(thr_q));
    assign win_done = (to_q != '0) && (win_inc == (TO_W+1)'(to_q));
    assign ack_now  = evt_req_q && bus.evt_ack;

    always_comb begin
        state_d   = state_q;
        thr_d     = thr_q;
        to_d      = to_q;
        run_cnt_d = run_cnt_q;
        win_cnt_d = win_cnt_q;
        evt_cnt_d = evt_cnt_q;
        evt_req_d = ack_now ? 1'b0 : evt_req_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = ARM;
                    thr_d     = (bus.thresh == '0) ? CNT_W'(1) : bus.thresh;
                    to_d      = bus.timeout;
                    run_cnt_d = '0;
                    win_cnt_d = '0;
                    evt_cnt_d = '0;
                end
            end
            ARM: begin
                if (bus.stop) begin
                    state_d   = IDLE;
                    evt_req_d = 1'b0;
                end else if (run_done) begin
                    state_d   = HIT;
                    evt_req_d = 1'b1;
                    evt_cnt_d = (evt_cnt_q == '1) ? evt_cnt_q : evt_cnt_q + EVT_W'(1);
                    run_cnt_d = '0;
                    win_cnt_d = '0;
                end else begin
                    run_cnt_d = bus.ina ? run_inc[CNT_W-1:0] : '0;
                    win_cnt_d = win_inc[TO_W-1:0];
                    if (win_done) state_d = TMO;
                end
            end
            HIT: begin
                // Leaving with a request still pending parks in REPORT so ARM
                // can never raise a second request on top of it.
                if (bus.stop) begin
                    state_d   = IDLE;
                    evt_req_d = 1'b0;
                end else if (!bus.ina) begin
                    state_d = evt_req_d ? REPORT : ARM;
                end
            end
            REPORT: begin
                if (bus.stop) begin
                    state_d   = IDLE;
                    evt_req_d = 1'b0;
                end else if (ack_now) begin
                    state_d   = ARM;
                    run_cnt_d = '0;
                    win_cnt_d = '0;
                end
            end
            TMO: begin
                state_d   = IDLE;
                evt_req_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                evt_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            thr_q     <= '0;
            to_q      <= '0;
            run_cnt_q <= '0;
            win_cnt_q <= '0;
            evt_cnt_q <= '0;
            evt_req_q <= 1'b0;
            busy_q    <= 1'b0;
            hit_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            thr_q     <= thr_d;
            to_q      <= to_d;
            run_cnt_q <= run_cnt_d;
            win_cnt_q <= win_cnt_d;
            evt_cnt_q <= evt_cnt_d;
            evt_req_q <= evt_req_d;
            busy_q    <= (state_d != IDLE);
            hit_q     <= (state_d == HIT);
            tmo_q     <= (state_d == TMO);
        end
    end

    assign bus.busy         = busy_q;
    assign bus.hit          = hit_q;
    assign bus.evt_req      = evt_req_q;
    assign bus.evt_cnt      = evt_cnt_q;
    assign bus.timeout_flag = tmo_q;
endmodule

// File: tb/tb_run_det_ctrl.sv
// Testbench for run_det_ctrl: two instances (8-bit and 2-bit event counters)
// driven identically, checked by directed scenarios and a random run.
module tb_run_det_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, stop = 1'b0, ina = 1'b0, evt_ack = 1'b0;
    logic [3:0] thresh = '0;
    logic [7:0] timeout = '0;

    int testCount = 0;
    int failCount = 0;

    // Behavioural model: phase flags plus an unbounded event count that is
    // clipped to each instance's counter width only when compared.
    bit mBusy, mHit, mReq, mTmo;
    int mThr, mTo, mRun, mWin, mCnt;

    run_det_ctrl_if #(.EVT_W(8)) busA ();
    run_det_ctrl_if #(.EVT_W(2)) busB ();

    assign busA.start = start;    assign busB.start = start;
    assign busA.stop = stop;      assign busB.stop = stop;
    assign busA.thresh = thresh;  assign busB.thresh = thresh;
    assign busA.timeout = timeout; assign busB.timeout = timeout;
    assign busA.ina = ina;        assign busB.ina = ina;
    assign busA.evt_ack = evt_ack; assign busB.evt_ack = evt_ack;

    run_det_ctrl #(.EVT_W(8)) dutA (.clk(clk), .rst(rst), .bus(busA));
    run_det_ctrl #(.EVT_W(2)) dutB (.clk(clk), .rst(rst), .bus(busB));

    always #5 clk = ~clk;

    function automatic logic [11:0] outsA();
        return {busA.busy, busA.hit, busA.evt_req, busA.timeout_flag, busA.evt_cnt};
    endfunction

    function automatic logic [11:0] outsB();
        return {busB.busy, busB.hit, busB.evt_req, busB.timeout_flag, 6'd0, busB.evt_cnt};
    endfunction

    function automatic logic [11:0] expVec(bit b, bit h, bit r, bit t, int c);
        return {b, h, r, t, c[7:0]};
    endfunction

    function automatic void modelReset();
        mBusy = 0; mHit = 0; mReq = 0; mTmo = 0;
        mThr = 0; mTo = 0; mRun = 0; mWin = 0; mCnt = 0;
    endfunction

    function automatic void modelStep();
        bit ackEff;
        ackEff = mReq && evt_ack;
        if (!mBusy) begin
            if (start) begin
                mBusy = 1; mThr = (thresh == 0) ? 1 : int'(thresh); mTo = int'(timeout);
                mRun = 0; mWin = 0; mCnt = 0;
            end
        end else if (stop) begin
            mBusy = 0; mHit = 0; mTmo = 0; mReq = 0;
        end else if (mTmo) begin
            mTmo = 0; mBusy = 0;
        end else if (mHit) begin
            if (ackEff) mReq = 0;
            if (!ina) mHit = 0;
        end else if (mReq) begin
            if (ackEff) begin mReq = 0; mRun = 0; mWin = 0; end
        end else begin
            mRun = ina ? mRun + 1 : 0;
            mWin = mWin + 1;
            if (mRun == mThr) begin
                mHit = 1; mReq = 1; mCnt = mCnt + 1; mRun = 0; mWin = 0;
            end else if (mTo != 0 && mWin == mTo) begin
                mTmo = 1;
            end
        end
    endfunction

    task automatic applyStimulus(input bit s, input bit sp, input int th, input int to,
                                 input bit in, input bit ak);
        start = s; stop = sp; thresh = th[3:0]; timeout = to[7:0]; ina = in; evt_ack = ak;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        modelReset();
        rst = 1'b0;
        #12;
        e = expVec(0, 0, 0, 0, 0);
        testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL reset_A: got %h want %h", outsA(), e); end
        testCount++;
        if (outsB() !== e) begin failCount++; $display("[TB] FAIL reset_B: got %h want %h", outsB(), e); end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_hit();
        logic [11:0] e;
        applyStimulus(1, 0, 3, 0, 0, 0);
        e = expVec(1, 0, 0, 0, 0); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL basic_arm: got %h want %h", outsA(), e); end
        applyStimulus(0, 0, 3, 0, 1, 0);
        applyStimulus(0, 0, 3, 0, 1, 0);
        e = expVec(1, 0, 0, 0, 0); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL basic_run2: got %h want %h", outsA(), e); end
        applyStimulus(0, 0, 3, 0, 1, 0);
        e = expVec(1, 1, 1, 0, 1); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL basic_hit: got %h want %h", outsA(), e); end
        applyStimulus(0, 0, 3, 0, 1, 0);
        testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL basic_hold: got %h want %h", outsA(), e); end
        applyStimulus(0, 0, 3, 0, 0, 0);
        e = expVec(1, 0, 1, 0, 1); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL basic_report: got %h want %h", outsA(), e); end
        applyStimulus(0, 1, 3, 0, 0, 0);
        e = expVec(0, 0, 0, 0, 1); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL basic_stop: got %h want %h", outsA(), e); end
    endtask

    task automatic test_ack_rearm();
        logic [11:0] e;
        bit seq [5] = '{1, 1, 0, 1, 1};
        applyStimulus(1, 0, 3, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 3, 0, 1, 0);
        applyStimulus(0, 0, 3, 0, 1, 1);
        e = expVec(1, 1, 0, 0, 1); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL ack_clear: got %h want %h", outsA(), e); end
        applyStimulus(0, 0, 3, 0, 0, 0);
        e = expVec(1, 0, 0, 0, 1); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL ack_rearm: got %h want %h", outsA(), e); end
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 3, 0, seq[i], 0);
        testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL ack_no_early: got %h want %h", outsA(), e); end
        applyStimulus(0, 0, 3, 0, 1, 0);
        e = expVec(1, 1, 1, 0, 2); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL ack_second: got %h want %h", outsA(), e); end
        applyStimulus(0, 1, 3, 0, 0, 0);
    endtask

    task automatic test_timeout();
        logic [11:0] e;
        bit seqA [4] = '{1, 0, 1, 0};
        bit seqB [4] = '{0, 0, 0, 1};
        applyStimulus(1, 0, 2, 5, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 2, 5, seqA[i], 0);
        e = expVec(1, 0, 0, 0, 0); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL to_pending: got %h want %h", outsA(), e); end
        applyStimulus(0, 0, 2, 5, 1, 0);
        e = expVec(1, 0, 0, 1, 0); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL to_flag: got %h want %h", outsA(), e); end
        applyStimulus(0, 0, 2, 5, 0, 0);
        e = expVec(0, 0, 0, 0, 0); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL to_idle: got %h want %h", outsA(), e); end
        applyStimulus(1, 0, 2, 5, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 2, 5, seqB[i], 0);
        applyStimulus(0, 0, 2, 5, 1, 0);
        e = expVec(1, 1, 1, 0, 1); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL to_hit_wins: got %h want %h", outsA(), e); end
        applyStimulus(0, 0, 2, 5, 1, 0);
        testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL to_no_flag: got %h want %h", outsA(), e); end
        applyStimulus(0, 1, 2, 5, 0, 0);
    endtask

    task automatic test_report();
        logic [11:0] e;
        applyStimulus(1, 0, 2, 5, 0, 0);
        applyStimulus(0, 0, 2, 5, 1, 0);
        applyStimulus(0, 0, 2, 5, 1, 0);
        applyStimulus(0, 0, 2, 5, 0, 0);
        e = expVec(1, 0, 1, 0, 1); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL rep_enter: got %h want %h", outsA(), e); end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 2, 5, 1'($urandom), 0);
            testCount++;
            if (outsA() !== e) begin failCount++; $display("[TB] FAIL rep_hold[%0d]: got %h want %h", i, outsA(), e); end
        end
        applyStimulus(0, 0, 2, 5, 1, 1);
        e = expVec(1, 0, 0, 0, 1); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL rep_ack: got %h want %h", outsA(), e); end
        applyStimulus(0, 0, 2, 5, 1, 0);
        testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL rep_run1: got %h want %h", outsA(), e); end
        applyStimulus(0, 0, 2, 5, 1, 0);
        e = expVec(1, 1, 1, 0, 2); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL rep_second: got %h want %h", outsA(), e); end
        applyStimulus(0, 1, 2, 5, 0, 0);
    endtask

    task automatic test_stop();
        logic [11:0] e;
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        applyStimulus(0, 1, 1, 0, 1, 1);
        e = expVec(0, 0, 0, 0, 1); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL stop_hit: got %h want %h", outsA(), e); end
        applyStimulus(1, 1, 3, 0, 0, 0);
        e = expVec(1, 0, 0, 0, 0); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL stop_restart: got %h want %h", outsA(), e); end
        applyStimulus(0, 1, 3, 0, 0, 0);
    endtask

    task automatic test_thresh_zero_sat();
        logic [11:0] e;
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) applyStimulus(0, 0, 0, 0, 0, 1);
            applyStimulus(0, 0, 0, 0, 1, 0);
            e = expVec(1, 1, 1, 0, k); testCount++;
            if (outsA() !== e) begin failCount++; $display("[TB] FAIL sat_A[%0d]: got %h want %h", k, outsA(), e); end
            e = expVec(1, 1, 1, 0, (k > 3) ? 3 : k); testCount++;
            if (outsB() !== e) begin failCount++; $display("[TB] FAIL sat_B[%0d]: got %h want %h", k, outsB(), e); end
        end
        applyStimulus(0, 1, 0, 0, 0, 0);
        e = expVec(0, 0, 0, 0, 3); testCount++;
        if (outsB() !== e) begin failCount++; $display("[TB] FAIL sat_B_kept: got %h want %h", outsB(), e); end
    endtask

    task automatic test_async_reset();
        logic [11:0] e;
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        start = 0; stop = 0; ina = 0; evt_ack = 0;
        #2;
        rst = 1'b0;
        #1;
        e = expVec(0, 0, 0, 0, 0); testCount++;
        if (outsA() !== e) begin failCount++; $display("[TB] FAIL async_A: got %h want %h", outsA(), e); end
        testCount++;
        if (outsB() !== e) begin failCount++; $display("[TB] FAIL async_B: got %h want %h", outsB(), e); end
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [11:0] eA, eB;
        int th, to;
        th = 3; to = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                th = $urandom_range(0, 4);
                to = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 20);
            end
            applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0, th, to,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
            eA = expVec(mBusy, mHit, mReq, mTmo, (mCnt > 255) ? 255 : mCnt);
            eB = expVec(mBusy, mHit, mReq, mTmo, (mCnt > 3) ? 3 : mCnt);
            testCount++;
            if (outsA() !== eA) begin failCount++; $display("[TB] FAIL rand_A[%0d]: got %h want %h", i, outsA(), eA); end
            testCount++;
            if (outsB() !== eB) begin failCount++; $display("[TB] FAIL rand_B[%0d]: got %h want %h", i, outsB(), eB); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_ack_rearm();
        test_timeout();
        test_report();
        test_stop();
        test_thresh_zero_sat();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
